// File: rtl/bpf_fetch_pipe.sv
// Instruction fetch front end for a BPF core: issues code-memory reads, buffers
// returned words through a short elastic pipe, and flushes on branch redirect or halt.
module bpf_fetch_pipe #(
  parameter int unsigned CODE_ADDR_WIDTH = 10,
  parameter int unsigned INSTR_WIDTH     = 64,
  parameter int unsigned PIPE_DEPTH      = 1,
  parameter int unsigned COUNT_WIDTH     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       halt,
  input  logic                       branch_mispredict,
  input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
  output logic                       inst_rd_en,
  output logic [CODE_ADDR_WIDTH-1:0] inst_addr,
  input  logic [INSTR_WIDTH-1:0]     instr_in,
  output logic [INSTR_WIDTH-1:0]     instr_out,
  output logic [CODE_ADDR_WIDTH-1:0] pc_out,
  output logic [COUNT_WIDTH-1:0]     icount_out,
  output logic                       vld,
  input  logic                       next_rdy,
  output logic                       busy
);

  localparam int unsigned             LAST    = PIPE_DEPTH - 1;
  localparam logic [COUNT_WIDTH-1:0]  CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state;
  logic [CODE_ADDR_WIDTH-1:0] pc;
  logic                       inflight;
  logic [CODE_ADDR_WIDTH-1:0] ret_pc;

  logic                       skid_v;
  logic [INSTR_WIDTH-1:0]     skid_instr;
  logic [CODE_ADDR_WIDTH-1:0] skid_pc;
  logic [COUNT_WIDTH-1:0]     skid_cnt;

  logic                       sv  [PIPE_DEPTH];
  logic [INSTR_WIDTH-1:0]     si  [PIPE_DEPTH];
  logic [CODE_ADDR_WIDTH-1:0] sp  [PIPE_DEPTH];
  logic [COUNT_WIDTH-1:0]     sc  [PIPE_DEPTH];
  logic                       adv [PIPE_DEPTH];
  logic                       acc [PIPE_DEPTH];

  logic flush;
  logic blocked0;
  logic to_skid;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + COUNT_WIDTH'(1);
  endfunction

  // Advance/accept chain, resolved from the output slice backwards so bubbles collapse
  always_comb begin
    for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
      adv[k] = 1'b0;
      acc[k] = 1'b0;
    end
    adv[LAST] = sv[LAST] & next_rdy;
    acc[LAST] = ~sv[LAST] | adv[LAST];
    for (int k = int'(PIPE_DEPTH) - 2; k >= 0; k--) begin
      adv[k] = sv[k] & acc[k+1];
      acc[k] = ~sv[k] | adv[k];
    end
  end

  assign flush      = halt | branch_mispredict;
  assign blocked0   = ~acc[0];
  assign to_skid    = inflight & blocked0;
  // A read whose data would find slice 0 blocked is withheld so the skid never overflows
  assign inst_rd_en = (state == RUN) & ~flush & ~skid_v & ~(inflight & blocked0);
  assign inst_addr  = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= '0;
      inflight   <= 1'b0;
      ret_pc     <= '0;
      skid_v     <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_cnt   <= '0;
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        sv[k] <= 1'b0;
        si[k] <= '0;
        sp[k] <= '0;
        sc[k] <= '0;
      end
    end else begin
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          pc    <= '0;
        end
      end else begin
        if (halt) begin
          state <= IDLE;
        end else if (branch_mispredict) begin
          pc <= branch_target;
        end else if (inst_rd_en) begin
          pc <= pc + CODE_ADDR_WIDTH'(1);
        end
      end

      inflight <= inst_rd_en;
      if (inst_rd_en) begin
        ret_pc <= pc;
      end

      if (flush) begin
        skid_v <= 1'b0;
        for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
          sv[k] <= 1'b0;
        end
      end else begin
        if (to_skid) begin
          skid_v     <= 1'b1;
          skid_instr <= instr_in;
          skid_pc    <= ret_pc;
          skid_cnt   <= '0;
        end else if (skid_v) begin
          if (acc[0]) begin
            skid_v <= 1'b0;
          end else begin
            skid_cnt <= sat_inc(skid_cnt);
          end
        end

        // Slice 0 takes the skid entry first, otherwise the fresh memory return
        if (acc[0]) begin
          sv[0] <= skid_v | inflight;
          if (skid_v) begin
            si[0] <= skid_instr;
            sp[0] <= skid_pc;
            sc[0] <= skid_cnt;
          end else if (inflight) begin
            si[0] <= instr_in;
            sp[0] <= ret_pc;
            sc[0] <= '0;
          end
        end else begin
          sc[0] <= sat_inc(sc[0]);
        end

        for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
          if (acc[k]) begin
            sv[k] <= sv[k-1];
            if (sv[k-1]) begin
              si[k] <= si[k-1];
              sp[k] <= sp[k-1];
              sc[k] <= sc[k-1];
            end
          end else begin
            sc[k] <= sat_inc(sc[k]);
          end
        end
      end
    end
  end

  assign instr_out  = si[LAST];
  assign pc_out     = sp[LAST];
  assign icount_out = sc[LAST];
  assign vld        = sv[LAST];
  assign busy       = (state == RUN);

endmodule

// File: tb/tb_bpf_fetch_pipe.sv
// Directed bench for bpf_fetch_pipe: a shallow 4-bit-PC instance and a 2-deep
// 10-bit-PC instance, each fed by a one-cycle-latency code memory model.
module tb_bpf_fetch_pipe;

  localparam int unsigned AW_A = 4;
  localparam int unsigned AW_B = 10;
  localparam int unsigned IW   = 64;
  localparam int unsigned CW   = 6;

  logic clk;
  logic rst;

  logic            start_a, halt_a, branch_mispredict_a, next_rdy_a;
  logic [AW_A-1:0] branch_target_a, inst_addr_a, pc_out_a;
  logic            inst_rd_en_a, vld_a, busy_a;
  logic [IW-1:0]   instr_in_a, instr_out_a;
  logic [CW-1:0]   icount_out_a;

  logic            start_b, halt_b, branch_mispredict_b, next_rdy_b;
  logic [AW_B-1:0] branch_target_b, inst_addr_b, pc_out_b;
  logic            inst_rd_en_b, vld_b, busy_b;
  logic [IW-1:0]   instr_in_b, instr_out_b;
  logic [CW-1:0]   icount_out_b;

  int checks = 0;
  int errors = 0;

  bpf_fetch_pipe #(.CODE_ADDR_WIDTH(AW_A), .INSTR_WIDTH(IW), .PIPE_DEPTH(1), .COUNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .halt(halt_a),
    .branch_mispredict(branch_mispredict_a), .branch_target(branch_target_a),
    .inst_rd_en(inst_rd_en_a), .inst_addr(inst_addr_a), .instr_in(instr_in_a),
    .instr_out(instr_out_a), .pc_out(pc_out_a), .icount_out(icount_out_a),
    .vld(vld_a), .next_rdy(next_rdy_a), .busy(busy_a)
  );

  bpf_fetch_pipe #(.CODE_ADDR_WIDTH(AW_B), .INSTR_WIDTH(IW), .PIPE_DEPTH(2), .COUNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .halt(halt_b),
    .branch_mispredict(branch_mispredict_b), .branch_target(branch_target_b),
    .inst_rd_en(inst_rd_en_b), .inst_addr(inst_addr_b), .instr_in(instr_in_b),
    .instr_out(instr_out_b), .pc_out(pc_out_b), .icount_out(icount_out_b),
    .vld(vld_b), .next_rdy(next_rdy_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] pat(input int unsigned a);
    return 64'hA5A5_0000_0000_0000 | IW'(a);
  endfunction

  // Code memory: data one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    instr_in_a <= inst_rd_en_a ? pat(32'(inst_addr_a)) : 64'hDEAD_DEAD_DEAD_DEAD;
    instr_in_b <= inst_rd_en_b ? pat(32'(inst_addr_b)) : 64'hDEAD_DEAD_DEAD_DEAD;
  end

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (inst_rd_en_a !== 1'b0 || inst_addr_a !== '0 || vld_a !== 1'b0 || instr_out_a !== '0 ||
        pc_out_a !== '0 || icount_out_a !== '0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: rd=%b addr=%h vld=%b instr=%h pc=%h cnt=%h busy=%b, want all 0",
               inst_rd_en_a, inst_addr_a, vld_a, instr_out_a, pc_out_a, icount_out_a, busy_a);
    end
    checks++;
    if (inst_rd_en_b !== 1'b0 || inst_addr_b !== '0 || vld_b !== 1'b0 || instr_out_b !== '0 ||
        pc_out_b !== '0 || icount_out_b !== '0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: rd=%b addr=%h vld=%b instr=%h pc=%h cnt=%h busy=%b, want all 0",
               inst_rd_en_b, inst_addr_b, vld_b, instr_out_b, pc_out_b, icount_out_b, busy_b);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (busy_a !== 1'b0 || inst_rd_en_a !== 1'b0 || busy_b !== 1'b0 || inst_rd_en_b !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy_a=%b rd_a=%b busy_b=%b rd_b=%b, want 0",
               busy_a, inst_rd_en_a, busy_b, inst_rd_en_b);
    end
  endtask

  task automatic test_sequential_fetch();
    @(negedge clk); start_a = 1'b1; next_rdy_a = 1'b1; #1;
    checks++;
    if (inst_rd_en_a !== 1'b0) begin
      errors++; $display("FAIL seq_c0_rd: got %b want 0", inst_rd_en_a);
    end
    @(negedge clk); start_a = 1'b0; #1;
    checks++;
    if (busy_a !== 1'b1 || inst_rd_en_a !== 1'b1 || inst_addr_a !== 4'd0) begin
      errors++;
      $display("FAIL seq_c1_issue: busy=%b rd=%b addr=%h want 1 1 0", busy_a, inst_rd_en_a, inst_addr_a);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_a !== 1'b0 || inst_rd_en_a !== 1'b1 || inst_addr_a !== 4'd1) begin
      errors++;
      $display("FAIL seq_c2: vld=%b rd=%b addr=%h want 0 1 1", vld_a, inst_rd_en_a, inst_addr_a);
    end
    // Runs past address 15 to show the wrap 14,15,0,1
    for (int c = 3; c <= 20; c++) begin
      @(negedge clk); #1;
      checks++;
      if (vld_a !== 1'b1 || pc_out_a !== 4'(c - 3) || instr_out_a !== pat(32'((c - 3) % 16)) ||
          icount_out_a !== '0) begin
        errors++;
        $display("FAIL seq_stream c=%0d: vld=%b pc=%0d instr=%h cnt=%0d want 1 %0d %h 0",
                 c, vld_a, pc_out_a, instr_out_a, icount_out_a, (c - 3) % 16, pat(32'((c - 3) % 16)));
      end
    end
  endtask

  task automatic test_stall_saturate();
    for (int j = 0; j < 70; j++) begin
      @(negedge clk);
      if (j == 0) next_rdy_a = 1'b0;
      #1;
      checks++;
      if (vld_a !== 1'b1 || pc_out_a !== 4'd2 || instr_out_a !== pat(2) || inst_rd_en_a !== 1'b0 ||
          icount_out_a !== 6'((j > 63) ? 63 : j)) begin
        errors++;
        $display("FAIL stall j=%0d: vld=%b pc=%0d instr=%h rd=%b cnt=%0d want 1 2 %h 0 %0d",
                 j, vld_a, pc_out_a, instr_out_a, inst_rd_en_a, icount_out_a, pat(2), (j > 63) ? 63 : j);
      end
    end
    @(negedge clk); next_rdy_a = 1'b1; #1;
    checks++;
    if (vld_a !== 1'b1 || pc_out_a !== 4'd2 || icount_out_a !== 6'd63) begin
      errors++;
      $display("FAIL stall_release_head: vld=%b pc=%0d cnt=%0d want 1 2 63", vld_a, pc_out_a, icount_out_a);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_a !== 1'b1 || pc_out_a !== 4'd3 || instr_out_a !== pat(3) || icount_out_a !== 6'd63 ||
        inst_rd_en_a !== 1'b1 || inst_addr_a !== 4'd4) begin
      errors++;
      $display("FAIL stall_skid_entry: vld=%b pc=%0d cnt=%0d rd=%b addr=%0d want 1 3 63 1 4",
               vld_a, pc_out_a, icount_out_a, inst_rd_en_a, inst_addr_a);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_a !== 1'b0) begin
      errors++; $display("FAIL stall_bubble: vld=%b want 0", vld_a);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_a !== 1'b1 || pc_out_a !== 4'd4 || instr_out_a !== pat(4) || icount_out_a !== '0) begin
      errors++;
      $display("FAIL stall_resume: vld=%b pc=%0d cnt=%0d want 1 4 0", vld_a, pc_out_a, icount_out_a);
    end
  endtask

  task automatic test_halt_and_mispredict();
    @(negedge clk); halt_a = 1'b1; branch_mispredict_a = 1'b1; branch_target_a = 4'h9; #1;
    checks++;
    if (inst_rd_en_a !== 1'b0 || vld_a !== 1'b1 || pc_out_a !== 4'd5) begin
      errors++;
      $display("FAIL halt_cycle: rd=%b vld=%b pc=%0d want 0 1 5", inst_rd_en_a, vld_a, pc_out_a);
    end
    @(negedge clk); halt_a = 1'b0; branch_mispredict_a = 1'b0; #1;
    checks++;
    if (busy_a !== 1'b0 || vld_a !== 1'b0 || inst_rd_en_a !== 1'b0 || pc_out_a !== 4'd5 ||
        instr_out_a !== pat(5)) begin
      errors++;
      $display("FAIL halt_after: busy=%b vld=%b rd=%b pc=%0d instr=%h want 0 0 0 5 %h",
               busy_a, vld_a, inst_rd_en_a, pc_out_a, instr_out_a, pat(5));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || vld_a !== 1'b0 || inst_rd_en_a !== 1'b0) begin
        errors++;
        $display("FAIL halt_idle c=%0d: busy=%b vld=%b rd=%b want 0 0 0", c, busy_a, vld_a, inst_rd_en_a);
      end
    end
  endtask

  task automatic test_back_pressure();
    int reads = 0;
    int exp_pc = 0;
    @(negedge clk); start_b = 1'b1; next_rdy_b = 1'b0; #1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start_b = 1'b0;
      #1;
      if (inst_rd_en_b === 1'b1) reads++;
      if (c == 1) begin
        checks++;
        if (inst_rd_en_b !== 1'b1 || inst_addr_b !== 10'd0) begin
          errors++; $display("FAIL bp_first_read: rd=%b addr=%0d want 1 0", inst_rd_en_b, inst_addr_b);
        end
      end
      checks++;
      if (c < 4) begin
        if (vld_b !== 1'b0) begin
          errors++; $display("FAIL bp_latency c=%0d: vld=%b want 0", c, vld_b);
        end
      end else if (vld_b !== 1'b1 || pc_out_b !== 10'd0 || instr_out_b !== pat(0) ||
                   icount_out_b !== 6'(c - 4)) begin
        errors++;
        $display("FAIL bp_hold c=%0d: vld=%b pc=%0d instr=%h cnt=%0d want 1 0 %h %0d",
                 c, vld_b, pc_out_b, instr_out_b, icount_out_b, pat(0), c - 4);
      end
    end
    checks++;
    if (reads != 3) begin
      errors++; $display("FAIL bp_buffered: reads=%0d want 3", reads);
    end
    for (int c = 9; c <= 20; c++) begin
      @(negedge clk);
      if (c == 9) next_rdy_b = 1'b1;
      #1;
      if (c == 9) begin
        checks++;
        if (icount_out_b !== 6'd5) begin
          errors++; $display("FAIL bp_head_count: cnt=%0d want 5", icount_out_b);
        end
      end
      if (vld_b === 1'b1) begin
        checks++;
        if (pc_out_b !== 10'(exp_pc) || instr_out_b !== pat(32'(exp_pc))) begin
          errors++;
          $display("FAIL bp_order c=%0d: pc=%0d instr=%h want %0d %h",
                   c, pc_out_b, instr_out_b, exp_pc, pat(32'(exp_pc)));
        end
        exp_pc++;
      end
    end
    checks++;
    if (exp_pc != 11) begin
      errors++; $display("FAIL bp_transfers: got %0d want 11", exp_pc);
    end
  endtask

  task automatic test_mispredict();
    @(negedge clk); branch_mispredict_b = 1'b1; branch_target_b = 10'h2A; #1;
    checks++;
    if (inst_rd_en_b !== 1'b0 || vld_b !== 1'b1 || pc_out_b !== 10'd11) begin
      errors++;
      $display("FAIL bm_cycle: rd=%b vld=%b pc=%0d want 0 1 11", inst_rd_en_b, vld_b, pc_out_b);
    end
    @(negedge clk); branch_mispredict_b = 1'b0; #1;
    checks++;
    if (vld_b !== 1'b0 || inst_rd_en_b !== 1'b1 || inst_addr_b !== 10'h2A) begin
      errors++;
      $display("FAIL bm_redirect: vld=%b rd=%b addr=%h want 0 1 2a", vld_b, inst_rd_en_b, inst_addr_b);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_b !== 1'b0 || inst_addr_b !== 10'h2B) begin
      errors++; $display("FAIL bm_c2: vld=%b addr=%h want 0 2b", vld_b, inst_addr_b);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_b !== 1'b0) begin
      errors++; $display("FAIL bm_c3: vld=%b pc=%h want vld 0", vld_b, pc_out_b);
    end
    @(negedge clk); #1;
    checks++;
    if (vld_b !== 1'b1 || pc_out_b !== 10'h2A || instr_out_b !== pat(32'h2A) || icount_out_b !== '0) begin
      errors++;
      $display("FAIL bm_first: vld=%b pc=%h instr=%h cnt=%0d want 1 2a %h 0",
               vld_b, pc_out_b, instr_out_b, icount_out_b, pat(32'h2A));
    end
    @(negedge clk); #1;
    checks++;
    if (vld_b !== 1'b1 || pc_out_b !== 10'h2B || inst_rd_en_b !== 1'b1 || inst_addr_b !== 10'h2E) begin
      errors++;
      $display("FAIL bm_second: vld=%b pc=%h rd=%b addr=%h want 1 2b 1 2e",
               vld_b, pc_out_b, inst_rd_en_b, inst_addr_b);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (inst_rd_en_b !== 1'b0 || inst_addr_b !== '0 || vld_b !== 1'b0 || instr_out_b !== '0 ||
        pc_out_b !== '0 || icount_out_b !== '0 || busy_b !== 1'b0 || instr_out_a !== '0 ||
        pc_out_a !== '0) begin
      errors++;
      $display("FAIL rst_async: rd=%b addr=%h vld=%b instr=%h pc=%h cnt=%h busy=%b instr_a=%h, want 0",
               inst_rd_en_b, inst_addr_b, vld_b, instr_out_b, pc_out_b, icount_out_b, busy_b, instr_out_a);
    end
    #2 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if (vld_b !== 1'b0 || busy_b !== 1'b0 || inst_rd_en_b !== 1'b0 || instr_out_b !== '0 ||
          pc_out_b !== '0) begin
        errors++;
        $display("FAIL rst_after c=%0d: vld=%b busy=%b rd=%b instr=%h pc=%h want 0",
                 c, vld_b, busy_b, inst_rd_en_b, instr_out_b, pc_out_b);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; halt_a = 1'b0; branch_mispredict_a = 1'b0; branch_target_a = '0; next_rdy_a = 1'b0;
    start_b = 1'b0; halt_b = 1'b0; branch_mispredict_b = 1'b0; branch_target_b = '0; next_rdy_b = 1'b0;
    test_reset();
    test_sequential_fetch();
    test_stall_saturate();
    test_halt_and_mispredict();
    test_back_pressure();
    test_mispredict();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
